psw_input_conditioner: RTL and testbench

- Front-end stage directly upstream of the password FSM.
- Synchronises and debounces the raw push-button and synchronises the 4-bit switch bank.
- On each clean button press, captures one switch digit and presents it on a valid/ready handshake.
- The downstream FSM therefore sees exactly one digit per physical press, never bounce-induced duplicates.

---
 rtl/psw_input_conditioner.sv | 140 ++++++++++++++
 tb/tb_psw_input_conditioner.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psw_input_conditioner.sv
// Synchronises/debounces the push-button and switch bank; one captured digit per clean press on valid/ready.
// Latency: digit_valid rises DEBOUNCE_CYCLES+2 edges after the press is first sampled; a capture while a digit is pending and ready is low is dropped and flags overrun.
module psw_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit KEY_ACTIVE_LOW  = 1'b1,
    parameter int DIGIT_W         = 4
) (
    input  logic               MAX10_CLK1_50,
    input  logic               rst,
    input  logic               key_raw,
    input  logic [DIGIT_W-1:0] sw_raw,
    input  logic               digit_ready,
    input  logic               clr_overrun,
    output logic [DIGIT_W-1:0] digit,
    output logic               digit_valid,
    output logic               key_pressed,
    output logic               overrun,
    output logic [1:0]         db_state
);

    localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [1:0] RELEASED     = 2'd0;
    localparam logic [1:0] PRESS_PEND   = 2'd1;
    localparam logic [1:0] HELD         = 2'd2;
    localparam logic [1:0] RELEASE_PEND = 2'd3;

    localparam logic KEY_IDLE = KEY_ACTIVE_LOW;

    logic               key_s1, key_s2, key_sync;
    logic [DIGIT_W-1:0] sw_s1, sw_s2;
    logic [1:0]         arm_pipe;
    logic               armed;
    logic [1:0]         state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               capture;
    logic               xfer;

    assign key_sync = key_s2 ^ KEY_ACTIVE_LOW;

    // A press still held across reset must be released before it can count again;
    // arm_pipe waits until the synchroniser carries post-reset samples.
    always_ff @(posedge MAX10_CLK1_50) begin
        if (rst) begin
            key_s1   <= KEY_IDLE;
            key_s2   <= KEY_IDLE;
            sw_s1    <= '0;
            sw_s2    <= '0;
            arm_pipe <= 2'b00;
            armed    <= 1'b0;
        end else begin
            key_s1   <= key_raw;
            key_s2   <= key_s1;
            sw_s1    <= sw_raw;
            sw_s2    <= sw_s1;
            arm_pipe <= {arm_pipe[0], 1'b1};
            if (arm_pipe[1] && !key_sync) begin
                armed <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        case (state)
            RELEASED: begin
                if (armed && key_sync) begin
                    state_nxt = PRESS_PEND;
                    cnt_nxt   = CNT_ONE;
                end
            end
            PRESS_PEND: begin
                if (!key_sync) begin
                    state_nxt = RELEASED;
                    cnt_nxt   = '0;
                end else if (cnt >= CNT_MAX) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                    capture   = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            HELD: begin
                if (!key_sync) begin
                    state_nxt = RELEASE_PEND;
                    cnt_nxt   = CNT_ONE;
                end
            end
            RELEASE_PEND: begin
                if (key_sync) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else if (cnt >= CNT_MAX) begin
                    state_nxt = RELEASED;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
        endcase
    end

    assign xfer = digit_valid && digit_ready;

    always_ff @(posedge MAX10_CLK1_50) begin
        if (rst) begin
            state       <= RELEASED;
            cnt         <= '0;
            digit       <= '0;
            digit_valid <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (capture) begin
                if (!digit_valid || digit_ready) begin
                    digit       <= sw_s2;
                    digit_valid <= 1'b1;
                end
            end else if (xfer) begin
                digit_valid <= 1'b0;
            end
            // A drop on the same edge as a clear leaves the flag set.
            if (capture && digit_valid && !digit_ready) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

    assign key_pressed = state[1];
    assign db_state    = state;

endmodule

// File: tb/tb_psw_input_conditioner.sv
// Bench for psw_input_conditioner with DEBOUNCE_CYCLES=4 and an active-high key.
module tb_psw_input_conditioner;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst, key_raw, digit_ready, clr_overrun;
    logic [3:0] sw_raw;
    logic [3:0] digit;
    logic       digit_valid, key_pressed, overrun;
    logic [1:0] db_state;

    psw_input_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .KEY_ACTIVE_LOW (1'b0),
        .DIGIT_W        (4)
    ) dut (
        .MAX10_CLK1_50(clk),
        .rst          (rst),
        .key_raw      (key_raw),
        .sw_raw       (sw_raw),
        .digit_ready  (digit_ready),
        .clr_overrun  (clr_overrun),
        .digit        (digit),
        .digit_valid  (digit_valid),
        .key_pressed  (key_pressed),
        .overrun      (overrun),
        .db_state     (db_state)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: key/switches seen two edges late; a level change is
    // accepted after D+1 consecutive differing samples.
    logic       kd1, kd2;
    logic [3:0] sd1, sd2, m_digit;
    bit         m_level, m_armed, m_valid, m_ovr;
    int         m_run, m_since;

    task automatic model_edge();
        bit p, cap, set;
        logic [3:0] swc;
        if (rst) begin
            kd1 = 1'b0; kd2 = 1'b0; sd1 = '0; sd2 = '0;
            m_level = 0; m_armed = 0; m_valid = 0; m_ovr = 0;
            m_digit = '0; m_run = 0; m_since = 0;
        end else begin
            p   = kd2;
            swc = sd2;
            if (m_since < 10) m_since++;
            cap = 0;
            if (!m_level && !m_armed) begin
                m_run = 0;
            end else if (p != m_level) begin
                m_run++;
                if (m_run == D + 1) begin
                    m_level = p;
                    m_run   = 0;
                    cap     = p;
                end
            end else begin
                m_run = 0;
            end
            if (m_since >= 3 && !p) m_armed = 1;
            set = 0;
            if (cap) begin
                if (!m_valid || digit_ready) begin
                    m_digit = swc;
                    m_valid = 1;
                end else begin
                    set = 1;
                end
            end else if (m_valid && digit_ready) begin
                m_valid = 0;
            end
            if (set) m_ovr = 1;
            else if (clr_overrun) m_ovr = 0;
            kd2 = kd1; kd1 = key_raw;
            sd2 = sd1; sd1 = sw_raw;
        end
    endtask

    int  prev_st  = 0;
    bit  prev_vld = 0;
    bit  saw_1to0 = 0;
    bit  kp_drop  = 0;
    int  n_rise   = 0;
    int  cyc      = 0;

    task automatic tick();
        int ms;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        ms = m_level ? (m_run != 0 ? 3 : 2) : (m_run != 0 ? 1 : 0);
        chk("model_state", int'(db_state), ms);
        chk("model_key_pressed", int'(key_pressed), int'(m_level));
        chk("model_valid", int'(digit_valid), int'(m_valid));
        chk("model_digit", int'(digit), int'(m_digit));
        chk("model_overrun", int'(overrun), int'(m_ovr));
        if (prev_st == 1 && db_state == 2'd0) saw_1to0 = 1;
        if (digit_valid && !prev_vld) n_rise++;
        if (!key_pressed) kp_drop = 1;
        prev_st  = int'(db_state);
        prev_vld = digit_valid;
        cyc++;
    endtask

    task automatic hold(input logic k, input int n);
        for (int i = 0; i < n; i++) begin
            key_raw = k;
            tick();
        end
    endtask

    typedef struct {
        logic       key;
        logic [1:0] st;
        logic       kp;
        logic       vld;
    } vec_t;

    vec_t tbl[17];

    function automatic vec_t mk(input logic k, input logic [1:0] s, input logic p, input logic v);
        vec_t r;
        r.key = k; r.st = s; r.kp = p; r.vld = v;
        return r;
    endfunction

    initial begin
        int base;
        // Clean press, sw=7, ready=1: key high for 10 edges then released.
        tbl[0]  = mk(1'b1, 2'd0, 1'b0, 1'b0);
        tbl[1]  = mk(1'b1, 2'd0, 1'b0, 1'b0);
        tbl[2]  = mk(1'b1, 2'd1, 1'b0, 1'b0);
        tbl[3]  = mk(1'b1, 2'd1, 1'b0, 1'b0);
        tbl[4]  = mk(1'b1, 2'd1, 1'b0, 1'b0);
        tbl[5]  = mk(1'b1, 2'd1, 1'b0, 1'b0);
        tbl[6]  = mk(1'b1, 2'd2, 1'b1, 1'b1);
        tbl[7]  = mk(1'b1, 2'd2, 1'b1, 1'b0);
        tbl[8]  = mk(1'b1, 2'd2, 1'b1, 1'b0);
        tbl[9]  = mk(1'b1, 2'd2, 1'b1, 1'b0);
        tbl[10] = mk(1'b0, 2'd2, 1'b1, 1'b0);
        tbl[11] = mk(1'b0, 2'd2, 1'b1, 1'b0);
        tbl[12] = mk(1'b0, 2'd3, 1'b1, 1'b0);
        tbl[13] = mk(1'b0, 2'd3, 1'b1, 1'b0);
        tbl[14] = mk(1'b0, 2'd3, 1'b1, 1'b0);
        tbl[15] = mk(1'b0, 2'd3, 1'b1, 1'b0);
        tbl[16] = mk(1'b0, 2'd0, 1'b0, 1'b0);

        rst = 1'b1; key_raw = 1'b0; sw_raw = 4'd0; digit_ready = 1'b1; clr_overrun = 1'b0;
        tick(); tick();
        chk("rst_digit", int'(digit), 0);
        chk("rst_valid", int'(digit_valid), 0);
        chk("rst_key_pressed", int'(key_pressed), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_state", int'(db_state), 0);
        rst = 1'b0; sw_raw = 4'd7;
        hold(1'b0, 6);

        for (int i = 0; i < 17; i++) begin
            key_raw = tbl[i].key;
            tick();
            chk($sformatf("tbl%0d_state", i), int'(db_state), int'(tbl[i].st));
            chk($sformatf("tbl%0d_kp", i), int'(key_pressed), int'(tbl[i].kp));
            chk($sformatf("tbl%0d_valid", i), int'(digit_valid), int'(tbl[i].vld));
            if (tbl[i].vld) chk($sformatf("tbl%0d_digit", i), int'(digit), 7);
        end
        hold(1'b0, 4);

        // Bouncy press
        sw_raw = 4'd3; saw_1to0 = 0; base = n_rise;
        hold(1'b1, 1); hold(1'b0, 1); hold(1'b1, 1); hold(1'b0, 1);
        hold(1'b1, 14);
        chk("bounce_state_1to0", int'(saw_1to0), 1);
        chk("bounce_one_valid", n_rise - base, 1);
        chk("bounce_digit", int'(digit), 3);
        hold(1'b0, 14);

        // Release bounce while held
        sw_raw = 4'd5;
        hold(1'b1, 12);
        base = n_rise; kp_drop = 0;
        hold(1'b0, 2); hold(1'b1, 10);
        chk("relbounce_kp_held", int'(kp_drop), 0);
        chk("relbounce_no_valid", n_rise - base, 0);
        hold(1'b0, 14);
        sw_raw = 4'd1;
        hold(1'b1, 12);
        chk("relbounce_next_valid", n_rise - base, 1);
        chk("relbounce_next_digit", int'(digit), 1);
        hold(1'b0, 14);

        // Back-pressure with a dropped press
        digit_ready = 1'b0; sw_raw = 4'd1;
        hold(1'b1, 12); hold(1'b0, 14);
        sw_raw = 4'd7;
        hold(1'b1, 12); hold(1'b0, 14);
        chk("bp_digit", int'(digit), 1);
        chk("bp_valid", int'(digit_valid), 1);
        chk("bp_overrun", int'(overrun), 1);
        digit_ready = 1'b1; tick(); digit_ready = 1'b0;
        chk("bp_valid_cleared", int'(digit_valid), 0);
        clr_overrun = 1'b1; tick(); clr_overrun = 1'b0;
        chk("bp_overrun_cleared", int'(overrun), 0);

        // Transfer and capture on the same edge
        sw_raw = 4'd1;
        hold(1'b1, 12); hold(1'b0, 14);
        chk("sim_pending", int'(digit_valid), 1);
        sw_raw = 4'd7;
        hold(1'b1, 6);
        digit_ready = 1'b1;
        hold(1'b1, 1);
        chk("sim_digit", int'(digit), 7);
        chk("sim_valid", int'(digit_valid), 1);
        chk("sim_overrun", int'(overrun), 0);
        hold(1'b1, 1);
        chk("sim_valid_taken", int'(digit_valid), 0);
        hold(1'b1, 4); hold(1'b0, 14);

        // Reset during PRESS_PEND, then while a digit is pending
        sw_raw = 4'd9;
        hold(1'b1, 3);
        chk("rst1_pre_pend", int'(db_state), 1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst1_state", int'(db_state), 0);
        chk("rst1_valid", int'(digit_valid), 0);
        chk("rst1_digit", int'(digit), 0);
        base = n_rise;
        hold(1'b1, 15);
        chk("rst1_no_valid_held", n_rise - base, 0);
        chk("rst1_still_released", int'(db_state), 0);
        hold(1'b0, 14);
        hold(1'b1, 12);
        chk("rst1_repress_valid", n_rise - base, 1);
        digit_ready = 1'b0;
        hold(1'b0, 14); hold(1'b1, 12);
        chk("rst2_pending", int'(digit_valid), 1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst2_valid", int'(digit_valid), 0);
        chk("rst2_digit", int'(digit), 0);
        chk("rst2_kp", int'(key_pressed), 0);
        chk("rst2_overrun", int'(overrun), 0);
        chk("rst2_state", int'(db_state), 0);
        hold(1'b1, 10);
        chk("rst2_no_valid", int'(digit_valid), 0);
        hold(1'b0, 14);

        // Randomised traffic against the model
        while (cyc < 4000) begin
            logic lvl;
            int   len;
            lvl = ($urandom_range(0, 1) == 1);
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(5, 14));
            for (int j = 0; j < len; j++) begin
                key_raw     = lvl;
                sw_raw      = 4'($urandom_range(0, 15));
                digit_ready = ($urandom_range(0, 3) != 0);
                clr_overrun = ($urandom_range(0, 29) == 0);
                rst         = ($urandom_range(0, 399) == 0);
                tick();
            end
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, cycles=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
